hazard_stall_ctrl: RTL

Pipeline hazard controller in the ID stage of the 5-stage MIPS core. It sits upstream of the ID/EX register and the forwarding unit. It detects load-use and branch-operand hazards that forwarding cannot cover, and drives PC/IF-ID write-enables, the ID/EX bubble and the IF/ID flush. Multi-cycle stalls are sequenced by a small FSM, and saturating stall/flush performance counters are kept.

---
 rtl/hazard_stall_ctrl_pkg.sv | 15 +
 rtl/hazard_stall_ctrl_sat_counter.sv | 13 +
 rtl/hazard_stall_ctrl.sv | 51 +++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the ID-stage hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, HOLD = 2'b01} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;
  localparam ctrl_t NOP_CTRL = '0;
endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage load-use/branch hazard stall and flush control
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             branch_taken,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [REG_W-1:0] idex_dest,
  input  logic             exmem_mem_read,
  input  logic [REG_W-1:0] exmem_dest,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t state;
  logic idex_hit, exmem_hit, lu, ba, bl2, bl1, stall;
  assign idex_hit  = idex_dest != REG_W'(REG_ZERO) &&
                     (idex_dest == ifid_rs || (id_uses_rt && idex_dest == ifid_rt));
  assign exmem_hit = exmem_dest != REG_W'(REG_ZERO) &&
                     (exmem_dest == ifid_rs || (id_uses_rt && exmem_dest == ifid_rt));
  assign lu  = idex_mem_read && idex_hit;
  assign ba  = id_branch && idex_reg_write && !idex_mem_read && idex_hit;
  assign bl2 = id_branch && idex_mem_read && idex_hit;
  assign bl1 = id_branch && exmem_mem_read && exmem_hit;
  // HOLD is the second cycle of a branch-on-load stall and ignores inputs
  assign stall       = (state == IDLE && (lu || ba || bl2 || bl1)) || state == HOLD;
  assign pc_write    = rst || !stall;
  assign ifid_write  = rst || !stall;
  assign idex_bubble = !rst && stall;
  assign ifid_flush  = !rst && !stall && (branch_taken || id_jump);
  assign state_o     = state;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= (state == IDLE && bl2) ? HOLD : IDLE;
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall), .count(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(ifid_flush), .count(flush_cnt));
endmodule
